rom_read_arbiter: RTL

- Sequences and shares one synchronous 32-bit ROM between two read requesters: port 0 (instruction fetch) and port 1 (debug/DMA loader).
- The ROM registers its output one cycle after it samples the address.
- Each requester issues burst read commands: start word address plus beat count. The arbiter grants round-robin, drives the ROM address incrementally and routes the returned data back with a last-beat marker.
- Sits between the AHB ROM slave datapath and its clients.

---
 rtl/rom_read_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/rom_read_arbiter.sv
// Round-robin burst read arbiter sharing one synchronous ROM between two
// requesters (port 0: instruction fetch, port 1: debug/DMA loader).
// The ROM registers its output one cycle after sampling rom_addr, so a
// one-stage valid/last pipeline tracks which beat the returned word belongs to.
module rom_read_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid0,
  output logic              req_ready0,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [3:0]        req_len0,
  output logic              rsp_valid0,
  output logic              rsp_last0,
  input  logic              req_valid1,
  output logic              req_ready1,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [3:0]        req_len1,
  output logic              rsp_valid1,
  output logic              rsp_last1,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt;
  logic [3:0]        remaining, remaining_nxt;
  logic              grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic              pipe_valid, pipe_valid_nxt;
  logic              pipe_last, pipe_last_nxt;
  logic              sel;

  // State register: all control state, cleared asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      rom_addr   <= '0;
      remaining  <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;  // port 0 wins the first contention
      pipe_valid <= 1'b0;
      pipe_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rom_addr   <= rom_addr_nxt;
      remaining  <= remaining_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      pipe_valid <= pipe_valid_nxt;
      pipe_last  <= pipe_last_nxt;
    end
  end

  // Arbitration, address sequencing and beat pipeline next-state logic.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    rom_addr_nxt   = rom_addr;
    remaining_nxt  = remaining;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    pipe_valid_nxt = 1'b0;
    pipe_last_nxt  = 1'b0;
    sel            = 1'b0;
    // A port yields only when the other is also asking and it won last time.
    req_ready0 = (state == IDLE) && req_valid0 && (!req_valid1 || last_grant != 1'b0);
    req_ready1 = (state == IDLE) && req_valid1 && (!req_valid0 || last_grant != 1'b1);

    case (state)
      IDLE: begin
        if (req_ready0 || req_ready1) begin
          sel            = req_ready1;
          rom_addr_nxt   = sel ? req_addr1 : req_addr0;
          remaining_nxt  = sel ? req_len1 : req_len0;
          grant_nxt      = sel;
          last_grant_nxt = sel;
          state_nxt      = BURST;
        end
      end
      BURST: begin
        // The ROM samples rom_addr on this edge; its word appears next cycle.
        pipe_valid_nxt = 1'b1;
        pipe_last_nxt  = (remaining == 4'd0);
        if (remaining != 4'd0) begin
          rom_addr_nxt  = rom_addr + 1'b1;  // wraps modulo 2^ADDR_W
          remaining_nxt = remaining - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid0 = pipe_valid && (grant_id == 1'b0);
  assign rsp_valid1 = pipe_valid && (grant_id == 1'b1);
  assign rsp_last0  = rsp_valid0 && pipe_last;
  assign rsp_last1  = rsp_valid1 && pipe_last;
  assign rsp_data   = rom_data;
  assign busy       = (state == BURST) || pipe_valid;

endmodule
